// File: rtl/dequeue_arbiter_v0_1_pkg.sv
// Shared scheduler constants and the egress dequeue FSM encoding.
package dequeue_arbiter_v0_1_pkg;
  localparam int QUEUE_NUM      = 5;
  localparam int ADDR_WIDTH     = 12;
  localparam int MAX_PKT_CHUNKS = 32;

  // A PIFO entry carries just the head buffer address of its packet.
  localparam int PIFO_FIELD_W   = ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_READ = 2'd2
  } dq_state_e;
endpackage

// File: rtl/dequeue_arbiter_v0_1_rr_arbiter.sv
// Combinational round-robin select: lowest request above last_grant, else lowest overall.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o
);
  logic [N-1:0] upper_mask, hi, pick;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) upper_mask[i] = (i > int'(last_grant_i));
    hi      = req_i & upper_mask;
    pick    = (hi != '0) ? hi : req_i;
    // Isolate the lowest set bit.
    grant_o = pick & (~pick + {{(N-1){1'b0}}, 1'b1});
  end
endmodule

// File: rtl/dequeue_arbiter_v0_1.sv
// Egress dequeue agent: round-robin pick of a ready port, pop its PIFO head, stream chunks.
module dequeue_arbiter_v0_1 #(
  parameter int QUEUE_NUM      = dequeue_arbiter_v0_1_pkg::QUEUE_NUM,
  parameter int ADDR_WIDTH     = dequeue_arbiter_v0_1_pkg::ADDR_WIDTH,
  parameter int MAX_PKT_CHUNKS = dequeue_arbiter_v0_1_pkg::MAX_PKT_CHUNKS
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [QUEUE_NUM-1:0]            s_pifo_empty,
  input  logic [QUEUE_NUM*ADDR_WIDTH-1:0] s_pifo_head_addr,
  input  logic [QUEUE_NUM-1:0]            s_port_ready,
  output logic [QUEUE_NUM-1:0]            m_pifo_out_en,
  output logic                            m_buf_rd_en,
  output logic [ADDR_WIDTH-1:0]           m_buf_rd_addr,
  input  logic                            s_buf_rd_valid,
  input  logic                            s_buf_rd_last,
  output logic [QUEUE_NUM-1:0]            m_port_sel,
  output logic                            m_busy,
  output logic                            m_err
);
  import dequeue_arbiter_v0_1_pkg::*;

  localparam int QW = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;
  localparam int CW = $clog2(MAX_PKT_CHUNKS + 1);

  dq_state_e             state_q, state_d;
  logic [QUEUE_NUM-1:0]  grant_q, grant_d, sel_q, sel_d, eligible, rr_grant;
  logic [QW-1:0]         last_q, last_d, grant_idx;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, head_sel;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d, rd_en, done_ok, done_wd;

  assign eligible = ~s_pifo_empty & s_port_ready;

  rr_arbiter #(.N(QUEUE_NUM), .LW(QW)) u_rr (
    .req_i        (eligible),
    .last_grant_i (last_q),
    .grant_o      (rr_grant)
  );

  always_comb begin
    grant_idx = '0;
    head_sel  = '0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      if (grant_q[i]) begin
        grant_idx = QW'(i);
        head_sel  = s_pifo_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rd_en   = (state_q == ST_READ) && |(s_port_ready & grant_q);
  assign done_ok = (state_q == ST_READ) && s_buf_rd_valid && s_buf_rd_last;
  assign done_wd = (state_q == ST_READ) && s_buf_rd_valid && !s_buf_rd_last &&
                   (cnt_q == CW'(MAX_PKT_CHUNKS - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    sel_d     = '0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          grant_d = rr_grant;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        rd_addr_d = head_sel;
        cnt_d     = '0;
        state_d   = ST_READ;
      end
      ST_READ: begin
        if (rd_en) rd_addr_d = rd_addr_q + 1'b1;
        if (s_buf_rd_valid) cnt_d = cnt_q + 1'b1;
        sel_d = rd_en ? grant_q : '0;
        // The read issued alongside the final chunk is an over-read; drop its steer.
        if (done_ok || done_wd) begin
          state_d = ST_IDLE;
          last_d  = grant_idx;
          sel_d   = '0;
          err_d   = done_wd;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= QW'(QUEUE_NUM - 1);
      rd_addr_q <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  assign m_pifo_out_en = (state_q == ST_POP) ? grant_q : '0;
  assign m_buf_rd_en   = rd_en;
  assign m_buf_rd_addr = rd_addr_q;
  assign m_port_sel    = sel_q;
  assign m_busy        = (state_q != ST_IDLE);
  assign m_err         = err_q;
endmodule

// File: tb/tb_dequeue_arbiter_v0_1.sv
// Randomized + directed bench for the dequeue arbiter against a cycle-level behavioural model.
module tb_dequeue_arbiter_v0_1;
  import dequeue_arbiter_v0_1_pkg::*;

  localparam int Q    = QUEUE_NUM;
  localparam int AW   = PIFO_FIELD_W;
  localparam int MAXC = MAX_PKT_CHUNKS;
  localparam int MEMN = 1 << AW;

  logic          axis_aclk = 1'b0;
  logic          axis_resetn;
  logic [Q-1:0]  s_pifo_empty, s_port_ready, m_pifo_out_en, m_port_sel;
  logic [Q*AW-1:0] s_pifo_head_addr;
  logic          m_buf_rd_en, s_buf_rd_valid, s_buf_rd_last, m_busy, m_err;
  logic [AW-1:0] m_buf_rd_addr;

  always #5 axis_aclk = ~axis_aclk;

  dequeue_arbiter_v0_1 #(.QUEUE_NUM(Q), .ADDR_WIDTH(AW), .MAX_PKT_CHUNKS(MAXC)) dut (
    .axis_aclk        (axis_aclk),
    .axis_resetn      (axis_resetn),
    .s_pifo_empty     (s_pifo_empty),
    .s_pifo_head_addr (s_pifo_head_addr),
    .s_port_ready     (s_port_ready),
    .m_pifo_out_en    (m_pifo_out_en),
    .m_buf_rd_en      (m_buf_rd_en),
    .m_buf_rd_addr    (m_buf_rd_addr),
    .s_buf_rd_valid   (s_buf_rd_valid),
    .s_buf_rd_last    (s_buf_rd_last),
    .m_port_sel       (m_port_sel),
    .m_busy           (m_busy),
    .m_err            (m_err)
  );

  int errs = 0, checks = 0;
  int pkts [Q];
  bit mem_last [MEMN];
  int popq [$];
  int rdq  [$];
  int selcnt, errcnt;

  // Behavioural model state: packet in flight, pending pop, pending steer/err.
  bit m_in_pkt, m_pop_due, m_sel_due, m_err_due;
  int m_port, m_last, m_addr, m_rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [Q-1:0] el, input int last);
    int p;
    p = -1;
    for (int k = 1; k <= Q; k++)
      if (p < 0 && el[(last + k) % Q]) p = (last + k) % Q;
    return p;
  endfunction

  // Buffer + PIFO environment: data returns one cycle after a read request.
  initial forever begin
    logic en;
    logic [AW-1:0] a;
    @(negedge axis_aclk);
    en = m_buf_rd_en;
    a  = m_buf_rd_addr;
    @(posedge axis_aclk);
    #1;
    s_buf_rd_valid = en;
    s_buf_rd_last  = en && mem_last[a];
    for (int i = 0; i < Q; i++) s_pifo_empty[i] = (pkts[i] == 0);
  end

  // Monitor and reference model.
  initial forever begin
    logic [Q-1:0] elig, exp_pop, exp_sel;
    bit exp_rd, sel_nxt, err_nxt;
    @(negedge axis_aclk);
    if (!axis_resetn) begin
      chk("rst_pop",  m_pifo_out_en, '0);
      chk("rst_rd",   m_buf_rd_en, 0);
      chk("rst_sel",  m_port_sel, '0);
      chk("rst_busy", m_busy, 0);
      chk("rst_err",  m_err, 0);
      m_in_pkt = 0; m_pop_due = 0; m_sel_due = 0; m_err_due = 0;
      m_port = 0; m_last = Q - 1; m_addr = 0; m_rx = 0;
    end else begin
      exp_pop = m_pop_due ? (Q'(1) << m_port) : '0;
      exp_sel = m_sel_due ? (Q'(1) << m_port) : '0;
      exp_rd  = m_in_pkt && s_port_ready[m_port];
      chk("pop",  m_pifo_out_en, exp_pop);
      chk("busy", m_busy, m_pop_due || m_in_pkt);
      chk("rd_en", m_buf_rd_en, exp_rd);
      if (exp_rd) chk("rd_addr", m_buf_rd_addr, m_addr);
      chk("sel",  m_port_sel, exp_sel);
      chk("err",  m_err, m_err_due);
      sel_nxt = 0;
      err_nxt = 0;
      if (m_pop_due) begin
        m_addr    = s_pifo_head_addr[m_port*AW +: AW];
        m_in_pkt  = 1;
        m_rx      = 0;
        m_pop_due = 0;
      end else if (m_in_pkt) begin
        if (exp_rd) begin
          sel_nxt = 1;
          m_addr  = (m_addr + 1) % MEMN;
        end
        if (s_buf_rd_valid) begin
          m_rx++;
          if (s_buf_rd_last) begin
            m_in_pkt = 0; m_last = m_port; sel_nxt = 0;
          end else if (m_rx == MAXC) begin
            m_in_pkt = 0; m_last = m_port; sel_nxt = 0; err_nxt = 1;
          end
        end
      end else begin
        elig = ~s_pifo_empty & s_port_ready;
        if (elig != '0) begin
          m_port    = rr_pick(elig, m_last);
          m_pop_due = 1;
        end
      end
      m_sel_due = sel_nxt;
      m_err_due = err_nxt;
      for (int i = 0; i < Q; i++)
        if (m_pifo_out_en[i]) begin
          popq.push_back(i);
          if (pkts[i] > 0) pkts[i]--;
        end
      if (m_buf_rd_en) rdq.push_back(int'(m_buf_rd_addr));
      if (m_port_sel != '0) selcnt++;
      if (m_err) errcnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axis_aclk);
    #1;
  endtask

  task automatic clear_q();
    popq.delete(); rdq.delete(); selcnt = 0; errcnt = 0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < MEMN; a++) mem_last[a] = 0;
  endtask

  task automatic set_head(input int p, input int a);
    s_pifo_head_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic do_reset();
    @(posedge axis_aclk); #1;
    axis_resetn = 0;
    for (int i = 0; i < Q; i++) pkts[i] = 0;
    tick(2);
    axis_resetn = 1;
    clear_q();
  endtask

  task automatic wait_reads(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (rdq.size() < n && b > 0) begin
      @(posedge axis_aclk);
      b--;
    end
    #1;
    chk(tag, rdq.size() >= n, 1);
  endtask

  initial begin
    axis_resetn = 0;
    s_port_ready = '1; s_pifo_head_addr = '0; s_pifo_empty = '1;
    s_buf_rd_valid = 0; s_buf_rd_last = 0;
    for (int i = 0; i < Q; i++) pkts[i] = 0;
    clear_mem();
    clear_q();
    tick(3);
    axis_resetn = 1;

    // Single port, 3-chunk packet
    clear_q(); set_head(2, 'h010); mem_last['h012] = 1; pkts[2] = 1;
    tick(15);
    chk("t1_npop", popq.size(), 1);
    if (popq.size() > 0) chk("t1_port", popq[0], 2);
    chk("t1_nrd", rdq.size(), 4);
    for (int k = 0; k < 4; k++) if (k < rdq.size()) chk("t1_addr", rdq[k], 'h010 + k);
    chk("t1_sel", selcnt, 3);
    chk("t1_idle", m_busy, 0);

    // All ports, 1-chunk packets: pure round robin
    do_reset(); clear_mem();
    for (int i = 0; i < Q; i++) begin
      set_head(i, i * 'h100); mem_last[i * 'h100] = 1; pkts[i] = 2;
    end
    tick(60);
    chk("t2_npop", popq.size(), 2 * Q);
    for (int k = 0; k < 6; k++) if (k < popq.size()) chk("t2_order", popq[k], k % Q);

    // Ready stall mid-packet
    clear_q(); clear_mem(); set_head(1, 'h200); mem_last['h205] = 1; pkts[1] = 1;
    wait_reads("t3_wait", 2, 20);
    s_port_ready[1] = 0;
    tick(4);
    s_port_ready[1] = 1;
    tick(25);
    chk("t3_nrd", rdq.size(), 7);
    for (int k = 0; k < 7; k++) if (k < rdq.size()) chk("t3_addr", rdq[k], 'h200 + k);
    chk("t3_sel", selcnt, 6);

    // Address wrap
    clear_q(); clear_mem(); set_head(0, 'hFFE); mem_last['h001] = 1; pkts[0] = 1;
    tick(20);
    chk("t4_nrd", rdq.size(), 5);
    if (rdq.size() >= 4) begin
      chk("t4_a0", rdq[0], 'hFFE); chk("t4_a1", rdq[1], 'hFFF);
      chk("t4_a2", rdq[2], 'h000); chk("t4_a3", rdq[3], 'h001);
    end

    // Watchdog
    do_reset(); clear_mem();
    set_head(3, 'h300); set_head(0, 'h400); mem_last['h400] = 1; pkts[3] = 1;
    tick(3);
    pkts[0] = 1;
    tick(60);
    chk("t5_err", errcnt, 1);
    chk("t5_npop", popq.size(), 2);
    if (popq.size() >= 2) begin
      chk("t5_first", popq[0], 3);
      chk("t5_next", popq[1], 0);
    end

    // Reset during READ
    clear_q(); clear_mem(); set_head(4, 'h500); pkts[4] = 1;
    wait_reads("t6_wait", 3, 20);
    axis_resetn = 0;
    #1;
    chk("t6_rd", m_buf_rd_en, 0);
    chk("t6_busy", m_busy, 0);
    chk("t6_sel", m_port_sel, '0);
    for (int i = 0; i < Q; i++) pkts[i] = 0;
    set_head(1, 'h100); set_head(3, 'h300); mem_last['h100] = 1; mem_last['h300] = 1;
    pkts[1] = 1; pkts[3] = 1;
    tick(2);
    clear_q();
    axis_resetn = 1;
    tick(30);
    chk("t6_npop", popq.size(), 2);
    if (popq.size() >= 2) begin
      chk("t6_first", popq[0], 1);
      chk("t6_second", popq[1], 3);
    end
    chk("t6_err", errcnt, 0);

    // Randomized traffic
    clear_q();
    for (int a = 0; a < MEMN; a++) mem_last[a] = ($urandom_range(0, 5) == 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < Q; i++) begin
        pkts[i] = $urandom_range(0, 1);
        s_port_ready[i] = ($urandom_range(0, 7) != 0);
        set_head(i, $urandom_range(0, MEMN - 1));
      end
      tick(1);
    end
    chk("rnd_active", popq.size() > 20, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
